lcd_write_seq: RTL

- Downstream byte-write sequencer for the HD44780-style character LCD path.
- Consumes the main controller's command set (lcd_enable, mode, lcd_cnt, reg_sel) and the byte selected by the external data mux.
- Drives the LCD pins with correct RS/DB setup, E pulse and hold timing, plus the post-write busy wait; returns a one-cycle lcd_finish when the burst of lcd_cnt+1 bytes is done.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_delay_cnt.sv | 40 ++++
 rtl/lcd_write_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//   Shared definitions for the character-LCD path: the write sequencer state
//   encoding, the mode constants used by the main controller, the byte index
//   width and the default pin timing (in clk cycles at 50 MHz).
// ---------------------------------------------------------------------------
package lcd_pkg;

  // Write sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EHIGH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } lcd_wr_state_t;

  // Burst mode: init uses the long post-byte wait, refresh the short one
  localparam logic LCD_INIT = 1'b1;
  localparam logic LCD_REF  = 1'b0;

  // Up to four bytes per burst
  localparam int BYTE_IDX_W = 2;

  // Default timing, shared with the controller
  localparam int LCD_T_SETUP     = 2;
  localparam int LCD_T_E_HIGH    = 12;
  localparam int LCD_T_HOLD      = 2;
  localparam int LCD_T_WAIT_INIT = 250000;  // 5 ms
  localparam int LCD_T_WAIT_REF  = 2500;    // 50 us
  localparam int LCD_CNT_W       = 18;      // holds the largest T_* minus one

endpackage

// File: rtl/lcd_delay_cnt.sv
// ---------------------------------------------------------------------------
// lcd_delay_cnt
//   Loadable down-counter with a zero flag. It is loaded with (cycles-1) on
//   entry to a timed state; the state is left in the cycle where zero is high.
//   The counter parks at zero when not reloaded.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset (count cleared)
//   load      in   load load_val on this edge (has priority over counting)
//   load_val  in   value to load, CNT_W bits
//   zero      out  count is zero
// ---------------------------------------------------------------------------
module lcd_delay_cnt
  import lcd_pkg::*;
#(
  parameter int CNT_W = LCD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_write_seq.sv
// ---------------------------------------------------------------------------
// lcd_write_seq
//   Byte-write sequencer for an HD44780-style character LCD. On a start
//   request it writes a burst of lcd_cnt+1 bytes; each byte goes through
//   SETUP (RS/DB settle, E low), EHIGH (E pulse), HOLD (RS/DB held, E low)
//   and WAIT (controller busy time, length chosen by mode). A one-cycle
//   lcd_finish pulse marks the end of the burst.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   lcd_enable  in   start request, only looked at in IDLE
//   mode        in   1 = init (long wait), 0 = refresh (short wait)
//   lcd_cnt     in   index of the last byte of the burst
//   reg_sel     in   RS value for the whole burst
//   db_in       in   byte selected by the external mux from byte_idx
//   byte_idx    out  index of the byte being written
//   lcd_rs      out  LCD RS pin
//   lcd_rw      out  LCD RW pin, always 0 (write only)
//   lcd_e       out  LCD E pin (registered)
//   lcd_db      out  LCD data pins (registered)
//   lcd_finish  out  one-cycle pulse when the burst is complete
//   busy        out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module lcd_write_seq
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = LCD_T_SETUP,
  parameter int T_E_HIGH    = LCD_T_E_HIGH,
  parameter int T_HOLD      = LCD_T_HOLD,
  parameter int T_WAIT_INIT = LCD_T_WAIT_INIT,
  parameter int T_WAIT_REF  = LCD_T_WAIT_REF,
  parameter int CNT_W       = LCD_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lcd_enable,
  input  logic                  mode,
  input  logic [BYTE_IDX_W-1:0] lcd_cnt,
  input  logic                  reg_sel,
  input  logic [7:0]            db_in,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_e,
  output logic [7:0]            lcd_db,
  output logic                  lcd_finish,
  output logic                  busy
);

  // Counter reload values: a state lasting N cycles starts at N-1
  localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EHIGH     = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_WAIT_INIT = CNT_W'(T_WAIT_INIT - 1);
  localparam logic [CNT_W-1:0] LD_WAIT_REF  = CNT_W'(T_WAIT_REF - 1);

  lcd_wr_state_t          state_reg, state_next;

  // Burst parameters captured at start; later input changes are ignored
  logic                   mode_reg;
  logic [BYTE_IDX_W-1:0]  cnt_reg;
  logic                   rs_reg;

  logic [BYTE_IDX_W-1:0]  idx_reg, idx_next;
  logic                   e_reg;
  logic [7:0]             db_reg;

  logic                   start;
  logic                   dly_load;
  logic [CNT_W-1:0]       dly_val;
  logic                   dly_zero;
  logic [CNT_W-1:0]       wait_val;

  assign wait_val = (mode_reg == LCD_INIT) ? LD_WAIT_INIT : LD_WAIT_REF;

  lcd_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_val),
    .zero     (dly_zero)
  );

  // -------------------------------------------------------------------------
  // Next-state logic. Every transition into a timed state reloads the delay
  // counter; DONE is a fixed single cycle and needs no load.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    start      = 1'b0;
    dly_load   = 1'b0;
    dly_val    = LD_SETUP;

    case (state_reg)
      ST_IDLE: begin
        if (lcd_enable) begin
          start      = 1'b1;
          idx_next   = '0;
          state_next = ST_SETUP;
          dly_load   = 1'b1;
          dly_val    = LD_SETUP;
        end
      end

      ST_SETUP: begin
        if (dly_zero) begin
          state_next = ST_EHIGH;
          dly_load   = 1'b1;
          dly_val    = LD_EHIGH;
        end
      end

      ST_EHIGH: begin
        if (dly_zero) begin
          state_next = ST_HOLD;
          dly_load   = 1'b1;
          dly_val    = LD_HOLD;
        end
      end

      ST_HOLD: begin
        if (dly_zero) begin
          state_next = ST_WAIT;
          dly_load   = 1'b1;
          dly_val    = wait_val;
        end
      end

      ST_WAIT: begin
        if (dly_zero) begin
          // byte_idx stops at the last byte, so it never passes cnt_reg
          if (idx_reg == cnt_reg) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_SETUP;
            dly_load   = 1'b1;
            dly_val    = LD_SETUP;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and pin registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      mode_reg  <= 1'b0;
      cnt_reg   <= '0;
      rs_reg    <= 1'b0;
      idx_reg   <= '0;
      e_reg     <= 1'b0;
      db_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      // E is registered from the next state so it is high exactly in EHIGH
      e_reg     <= (state_next == ST_EHIGH);

      if (start) begin
        mode_reg <= mode;
        cnt_reg  <= lcd_cnt;
        rs_reg   <= reg_sel;
      end

      // Sampled on every SETUP edge; the value from the last SETUP cycle is
      // the one presented while E is high and through HOLD.
      if (state_reg == ST_SETUP) begin
        db_reg <= db_in;
      end
    end
  end

  assign byte_idx   = idx_reg;
  assign lcd_rs     = rs_reg;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = e_reg;
  assign lcd_db     = db_reg;
  assign lcd_finish = (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE);

endmodule
